// File: rtl/alu_seq_pkg.sv
// Shared definitions for the LC-3 operate-instruction sequencer.
// Contents: opcode constants, ALU function encodings, sequencer state enum,
// the default reset value of the condition codes and the legality check.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    localparam logic [2:0] CC_RESET_DEFAULT = 3'b010;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StReq,
        StGate,
        StIll
    } state_e;

    // NOT carries a mandatory all-ones trailer in bits [5:0].
    function automatic logic is_legal(input logic [15:0] word);
        logic ok;
        ok = 1'b0;
        case (word[15:12])
            OP_ADD:  ok = 1'b1;
            OP_AND:  ok = 1'b1;
            OP_NOT:  ok = (word[5:0] == 6'b111111);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_cc_gen.sv
// cc_gen: combinational bus-to-NZP condition-code generator.
// Ports:
//   bus - 16-bit value on the shared bus
//   nzp - {N, Z, P} for that value
module cc_gen (
    input  logic [15:0] bus,
    output logic [2:0]  nzp
);

    logic zero;

    assign zero = (bus == 16'h0000);
    assign nzp  = {bus[15], zero, !bus[15] && !zero};

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: control sequencer for the LC-3 ADD, AND and NOT instructions.
// Accepts one instruction word, waits out the register-file read latency,
// requests the shared bus, gates the ALU onto it after grant, loads the
// destination register and updates NZP from the bus value.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   instr_vld/instr/instr_rdy - instruction handshake (ready only when idle)
//   sr1_addr/sr2_addr/dr_addr - register-file addresses
//   aluk/ir_slice           - ALU function and immediate field
//   bus_req/bus_grant       - shared-bus arbitration
//   gate_alu_en/bus         - ALU bus drive and bus read-back
//   ld_reg/ld_cc/nzp        - register and condition-code update
//   done/illegal            - one-cycle retire / drop pulses
// All outputs are decoded from flops only.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned RD_WAIT  = 1,
    parameter logic [2:0]  CC_RESET = CC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_vld,
    input  logic [15:0] instr,
    output logic        instr_rdy,
    output logic [2:0]  sr1_addr,
    output logic [2:0]  sr2_addr,
    output logic [1:0]  aluk,
    output logic [5:0]  ir_slice,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic        gate_alu_en,
    input  logic [15:0] bus,
    output logic        ld_reg,
    output logic [2:0]  dr_addr,
    output logic        ld_cc,
    output logic [2:0]  nzp,
    output logic        done,
    output logic        illegal
);

    localparam logic [2:0] RD_LOAD = 3'(RD_WAIT - 1);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [2:0]  rd_cnt_q, rd_cnt_d;
    logic [2:0]  nzp_q, nzp_d;
    logic [2:0]  bus_nzp;

    cc_gen u_cc_gen (
        .bus (bus),
        .nzp (bus_nzp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ir_q     <= '0;
            rd_cnt_q <= '0;
            nzp_q    <= CC_RESET;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            rd_cnt_q <= rd_cnt_d;
            nzp_q    <= nzp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        rd_cnt_d = rd_cnt_q;
        nzp_d    = nzp_q;
        case (state_q)
            StIdle: begin
                if (instr_vld) begin
                    ir_d = instr;
                    if (is_legal(instr)) begin
                        rd_cnt_d = RD_LOAD;
                        state_d  = StRd;
                    end else begin
                        state_d = StIll;
                    end
                end
            end
            StRd: begin
                if (rd_cnt_q == 3'd0) begin
                    state_d = StReq;
                end else begin
                    rd_cnt_d = rd_cnt_q - 3'd1;
                end
            end
            StReq: begin
                if (bus_grant) begin
                    state_d = StGate;
                end
            end
            StGate: begin
                // Grant may drop here; the arbiter guarantees this one cycle.
                nzp_d   = bus_nzp;
                state_d = StIdle;
            end
            StIll: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        aluk = ALUK_ADD;
        case (ir_q[15:12])
            OP_AND:  aluk = ALUK_AND;
            OP_NOT:  aluk = ALUK_NOT;
            default: aluk = ALUK_ADD;
        endcase
    end

    assign instr_rdy   = (state_q == StIdle);
    assign bus_req     = (state_q == StReq) || (state_q == StGate);
    assign gate_alu_en = (state_q == StGate);
    assign ld_reg      = (state_q == StGate);
    assign ld_cc       = (state_q == StGate);
    assign done        = (state_q == StGate);
    assign illegal     = (state_q == StIll);

    assign dr_addr  = ir_q[11:9];
    assign sr1_addr = ir_q[8:6];
    assign sr2_addr = ir_q[2:0];
    assign ir_slice = ir_q[5:0];
    assign nzp      = nzp_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a register file and ALU model drive
// the bus, directed instructions push hand-computed results, a monitor pops
// and compares whenever done or illegal pulses.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_vld;
    logic [15:0] instr;
    logic        instr_rdy;
    logic [2:0]  sr1_addr;
    logic [2:0]  sr2_addr;
    logic [1:0]  aluk;
    logic [5:0]  ir_slice;
    logic        bus_req;
    logic        bus_grant;
    logic        gate_alu_en;
    logic [15:0] bus;
    logic        ld_reg;
    logic [2:0]  dr_addr;
    logic        ld_cc;
    logic [2:0]  nzp;
    logic        done;
    logic        illegal;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          is_ill;
        logic [1:0]  aluk;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [2:0]  dr;
        logic [5:0]  slice;
        logic [15:0] bus;
        logic [2:0]  nzp;
    } exp_t;

    exp_t sb[$];

    alu_op_sequencer #(
        .RD_WAIT  (1),
        .CC_RESET (3'b010)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_vld   (instr_vld),
        .instr       (instr),
        .instr_rdy   (instr_rdy),
        .sr1_addr    (sr1_addr),
        .sr2_addr    (sr2_addr),
        .aluk        (aluk),
        .ir_slice    (ir_slice),
        .bus_req     (bus_req),
        .bus_grant   (bus_grant),
        .gate_alu_en (gate_alu_en),
        .bus         (bus),
        .ld_reg      (ld_reg),
        .dr_addr     (dr_addr),
        .ld_cc       (ld_cc),
        .nzp         (nzp),
        .done        (done),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file and ALU datapath model.
    logic [15:0] regs [8];
    logic        poke_en;
    logic [2:0]  poke_addr;
    logic [15:0] poke_data;
    logic [15:0] opa, opb, alu_out;

    always @(posedge clk) begin
        if (ld_reg) regs[dr_addr] <= bus;
        else if (poke_en) regs[poke_addr] <= poke_data;
    end

    always_comb begin
        opa = regs[sr1_addr];
        opb = ir_slice[5] ? {{11{ir_slice[4]}}, ir_slice[4:0]} : regs[sr2_addr];
        case (aluk)
            2'b00:   alu_out = opa + opb;
            2'b01:   alu_out = opa & opb;
            2'b10:   alu_out = ~opa;
            default: alu_out = opa;
        endcase
    end

    assign bus = gate_alu_en ? alu_out : 16'h0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic push_exp(input bit is_ill, input logic [1:0] a, input logic [2:0] s1,
                            input logic [2:0] s2, input logic [2:0] d, input logic [5:0] sl,
                            input logic [15:0] b, input logic [2:0] cc);
        exp_t e;
        e.is_ill = is_ill; e.aluk = a; e.sr1 = s1; e.sr2 = s2; e.dr = d;
        e.slice = sl; e.bus = b; e.nzp = cc;
        sb.push_back(e);
    endtask

    task automatic poke(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Issue one word and measure cycles from the accept cycle to done/illegal.
    task automatic issue(input logic [15:0] w, input int exp_lat, input bit exp_ill,
                         input string nm);
        int n;
        bit seen;
        bit any_ctrl;
        @(negedge clk);
        n = 0;
        while (!instr_rdy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_rdy"}, instr_rdy, 1'b1);
        instr = w;
        instr_vld = 1'b1;
        @(posedge clk);
        #1 instr_vld = 1'b0;
        n = 0;
        seen = 0;
        any_ctrl = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            any_ctrl = any_ctrl | bus_req | gate_alu_en | ld_reg | ld_cc;
            if (done || illegal) seen = 1;
        end
        chk({nm, "_latency"}, n, exp_lat);
        if (exp_ill) begin
            chk({nm, "_no_bus_ctrl"}, any_ctrl, 1'b0);
        end else begin
            @(negedge clk);
            chk({nm, "_rdy_after_gate"}, instr_rdy, 1'b1);
        end
    endtask

    // Monitor: pops on each done/illegal pulse.
    bit         pend_nzp = 0;
    logic [2:0] pend_val;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pend_nzp) begin
                chk("nzp_after_gate", nzp, pend_val);
                pend_nzp <= 0;
            end
            if (!done) chk("ctrl_idle", {gate_alu_en, ld_reg, ld_cc}, 3'b000);
            if (done || illegal) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {done, illegal}, 2'b00);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pulse_kind", {done, illegal}, e.is_ill ? 2'b01 : 2'b10);
                    if (e.is_ill) begin
                        chk("ill_bus_req", bus_req, 1'b0);
                        chk("ill_nzp", nzp, e.nzp);
                    end else begin
                        chk("aluk", aluk, e.aluk);
                        chk("sr1_addr", sr1_addr, e.sr1);
                        chk("sr2_addr", sr2_addr, e.sr2);
                        chk("dr_addr", dr_addr, e.dr);
                        chk("ir_slice", ir_slice, e.slice);
                        chk("bus", bus, e.bus);
                        chk("gate_ctrl", {bus_req, gate_alu_en, ld_reg, ld_cc}, 4'hF);
                        pend_nzp <= 1;
                        pend_val <= e.nzp;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; instr_vld = 1'b0; instr = 16'h0000; bus_grant = 1'b1;
        poke_en = 1'b0; poke_addr = 3'd0; poke_data = 16'h0000;
        #23;
        chk("rst_instr_rdy", instr_rdy, 1'b1);
        chk("rst_nzp", nzp, 3'b010);
        chk("rst_ctrl", {bus_req, gate_alu_en, ld_reg, ld_cc, done, illegal}, 6'b0);
        chk("rst_fields", {aluk, sr1_addr, sr2_addr, dr_addr, ir_slice}, 17'b0);
        @(negedge clk);
        rst_n = 1'b1;
        poke(3'd1, 16'h0005);
        poke(3'd2, 16'hFFF9);

        // ADD R3,R1,R2: 5 + 0xFFF9 = 0xFFFE, negative.
        push_exp(0, 2'b00, 3'd1, 3'd2, 3'd3, 6'b000010, 16'hFFFE, 3'b100);
        issue(16'h1642, 3, 0, "add_reg");

        // AND R1,R1,#0
        push_exp(0, 2'b01, 3'd1, 3'd0, 3'd1, 6'b100000, 16'h0000, 3'b010);
        issue(16'h5260, 3, 0, "and_imm");

        // NOT R2,R1 with R1 = 0x8000
        poke(3'd1, 16'h8000);
        push_exp(0, 2'b10, 3'd1, 3'd7, 3'd2, 6'b111111, 16'h7FFF, 3'b001);
        issue(16'h947F, 3, 0, "not");

        // Illegal words leave nzp at 001.
        push_exp(1, 2'b00, 3'd0, 3'd0, 3'd0, 6'b0, 16'h0, 3'b001);
        issue(16'h9440, 1, 1, "ill_not");
        push_exp(1, 2'b00, 3'd0, 3'd0, 3'd0, 6'b0, 16'h0, 3'b001);
        issue(16'h2000, 1, 1, "ill_ld");

        // ADD R4,R1,#1 with grant withheld for 5 REQ cycles: 0x8001.
        bus_grant = 1'b0;
        push_exp(0, 2'b00, 3'd1, 3'd1, 3'd4, 6'b100001, 16'h8001, 3'b100);
        fork
            issue(16'h1861, 8, 0, "add_withheld");
            begin
                int c;
                int guard;
                c = 0;
                guard = 0;
                while (c < 5 && guard < 40) begin
                    @(negedge clk);
                    guard++;
                    if (bus_req) begin
                        c++;
                        if (c == 2) begin
                            instr = 16'h2000;
                            instr_vld = 1'b1;
                        end
                    end
                end
                chk("withheld_req_cycles", c, 5);
                @(posedge clk);
                #1;
                instr_vld = 1'b0;
                bus_grant = 1'b1;
            end
        join

        // Reset during GATE: bus controls drop at once, no done pulse.
        @(negedge clk);
        instr = 16'h1642;
        instr_vld = 1'b1;
        @(posedge clk);
        #1 instr_vld = 1'b0;
        begin
            int g;
            g = 0;
            while (!gate_alu_en && g < 20) begin
                @(posedge clk);
                #1;
                g++;
            end
            chk("rst_test_reached_gate", gate_alu_en, 1'b1);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", {gate_alu_en, bus_req, ld_reg, done}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_nzp", nzp, 3'b010);
        chk("post_rst_rdy", instr_rdy, 1'b1);

        // AND R5,R2,R2 with R2 = 0x7FFF after reset.
        push_exp(0, 2'b01, 3'd2, 3'd2, 3'd5, 6'b000010, 16'h7FFF, 3'b001);
        issue(16'h5A82, 3, 0, "and_reg_post_rst");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control sequencer for the LC-3 operate instructions ADD, AND and NOT.
- Accepts one instruction word over a valid/ready handshake and drives the ALU datapath controls: register-file read addresses, aluk, ir_slice and gate_alu_en.
- Requests the shared 16-bit bus from the bus arbiter, and drives the ALU onto the bus only after grant.
- Loads the destination register and updates the NZP condition codes from the bus value.

Parameters:
- RD_WAIT, 1: register-file read latency in cycles, before the bus is requested; legal range 1..7.
- CC_RESET, 3'b010: NZP value after reset (Z set).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr_vld  input  1  instruction word valid
- instr  input  16  LC-3 instruction word
- instr_rdy  output  1  sequencer can accept an instruction; high only in IDLE
- sr1_addr  output  3  register-file read port 1 address
- sr2_addr  output  3  register-file read port 2 address
- aluk  output  2  ALU function: 00 add, 01 and, 10 not
- ir_slice  output  6  ALU immediate field (imm-select bit plus imm5)
- bus_req  output  1  request for the shared bus
- bus_grant  input  1  bus granted by the arbiter
- gate_alu_en  output  1  ALU drives the bus
- bus  input  16  shared bus value (read back)
- ld_reg  output  1  write bus value to the register-file entry at dr_addr
- dr_addr  output  3  destination register
- ld_cc  output  1  condition-code update strobe
- nzp  output  3  condition codes {N,Z,P}
- done  output  1  one-cycle pulse: instruction retired
- illegal  output  1  one-cycle pulse: unsupported instruction word dropped

Behaviour:
- Clock, reset and output timing:
  - One clock.
  - Reset is asynchronous and active-low on rst_n.
  - All outputs are decoded from flops only; no combinational input-to-output path.
- Reset values:
  - state = IDLE, instr_rdy = 1, nzp = CC_RESET.
  - All other outputs are 0, including ir_q, rd_cnt, the address outputs and aluk.
- Accept: when instr_vld && instr_rdy, instr is latched into ir_q at the clock edge.
  - Opcode ir_q[15:12] = 0001 (ADD) gives aluk 00; 0101 (AND) gives aluk 01.
  - Opcode 1001 (NOT) is legal only if ir_q[5:0] = 111111, and gives aluk 10.
- Illegal word (any other opcode, or NOT with ir_q[5:0] != 111111):
  - Next state is ILL: illegal = 1 for one cycle, then IDLE.
  - bus_req, gate_alu_en, ld_reg and ld_cc are never asserted.
- Field mapping from ir_q, held stable from RD through GATE:
  - dr_addr = ir_q[11:9]
  - sr1_addr = ir_q[8:6]
  - sr2_addr = ir_q[2:0]
  - ir_slice = ir_q[5:0]
- State sequence for a legal word:
  - IDLE: on accept, load rd_cnt = RD_WAIT-1 and go to RD.
  - RD: decrement rd_cnt; go to REQ when rd_cnt = 0.
  - REQ: bus_req = 1; stay until bus_grant is sampled 1, then go to GATE.
  - GATE, exactly one cycle:
    - bus_req = 1, gate_alu_en = 1, ld_reg = 1, ld_cc = 1, done = 1.
    - At the closing edge, nzp <= {bus[15], bus == 0, !bus[15] && bus != 0}.
    - Then go to IDLE.
- Latency:
  - Accept edge to the GATE cycle = RD_WAIT + 2 cycles when grant is already high.
  - Each cycle of grant withholding adds one cycle.
  - Back-to-back instructions: instr_rdy returns in the cycle after GATE. Minimum issue interval is RD_WAIT + 3 cycles.
- Grant rules:
  - bus_grant outside REQ/GATE is ignored.
  - Grant dropping during GATE does not abort the operation; the arbiter guarantees a one-cycle minimum tenure once the request is sampled.
- aluk 11 (pass) is never generated.
- nzp changes only at the GATE edge. Illegal words and reset are the only other events affecting sequencing; illegal words leave nzp unchanged.
- Reset mid-operation:
  - gate_alu_en, bus_req and ld_reg deassert immediately (asynchronous).
  - The in-flight instruction is lost, with no done or illegal pulse.
- instr_vld while not in IDLE is ignored. Upstream holds instr stable until accepted.

Decomposition:
- Package alu_seq_pkg:
  - opcode constants OP_ADD = 4'b0001, OP_AND = 4'b0101, OP_NOT = 4'b1001
  - aluk encodings ALUK_ADD/AND/NOT/PASS
  - state enum IDLE/RD/REQ/GATE/ILL
  - default CC_RESET
- One sub-module is natural: cc_gen, the combinational bus-to-NZP generator, reused later by the LD/LEA sequencers.

Test Plan:
- ADD, register form: R1 = 0x0005, R2 = 0xFFF9, instr 0x1441 (ADD R2,R1,R1… use R3 = R1+R2: 0x1642), grant tied high, RD_WAIT = 1.
  - Response: aluk = 00, sr1_addr = 1, sr2_addr = 2.
  - GATE occurs 3 cycles after accept; bus = 0xFFFE, ld_reg with dr_addr = 3, nzp = 100, one done pulse.
- AND, immediate form: instr 0x5260 (AND R1,R1,#0).
  - Response: ir_slice = 6'b100000, aluk = 01, bus = 0x0000, nzp = 010.
- NOT: instr 0x947F (NOT R2,R1) with R1 = 0x8000.
  - Response: aluk = 10, bus = 0x7FFF, nzp = 001.
- Illegal word: instr 0x9440 (NOT with bits[5:0] = 000000), then instr 0x2000 (LD opcode).
  - Response: an illegal pulse for each; bus_req, gate_alu_en and ld_reg are never high; nzp unchanged.
- Grant withheld: bus_grant low for 5 cycles during REQ.
  - Response: bus_req is held high for 5 cycles; GATE follows one cycle after grant is sampled; instr_vld pulses during the wait are ignored.
- Reset mid-operation: assert rst_n low during GATE.
  - Response: gate_alu_en drops before the next clock edge; nzp = 010, instr_rdy = 1 after release; no done pulse.
